// File: rtl/time_set_pkg.sv
// Shared definitions for the time-entry block: FSM state encoding, field codes
// and the legal ranges of the edited time fields.
package time_set_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EDIT_H  = 3'd1,
        ST_EDIT_M  = 3'd2,
        ST_EDIT_S  = 3'd3,
        ST_EDIT_AP = 3'd4,
        ST_COMMIT  = 3'd5
    } state_t;

    localparam logic [1:0] FLD_H  = 2'd0;
    localparam logic [1:0] FLD_M  = 2'd1;
    localparam logic [1:0] FLD_S  = 2'd2;
    localparam logic [1:0] FLD_AP = 2'd3;

    localparam int HOURS24_MAX = 23;
    localparam int HOURS12_MIN = 1;
    localparam int HOURS12_MAX = 12;
    localparam int MINSEC_MAX  = 59;

    // Field being edited in a given state; non-edit states report hours.
    function automatic logic [1:0] state_field(input state_t s);
        logic [1:0] f;
        f = FLD_H;
        case (s)
            ST_EDIT_M:  f = FLD_M;
            ST_EDIT_S:  f = FLD_S;
            ST_EDIT_AP: f = FLD_AP;
            default:    f = FLD_H;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// W-bit up/down counter bounded to [lo, hi] with wrap-around in both
// directions and a synchronous re-initialise input that beats stepping.
module wrap_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] rst_val,
    input  logic         up,
    input  logic         down,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic         init,
    input  logic [W-1:0] init_val,
    output logic [W-1:0] value
);

    logic [W-1:0] value_reg;
    logic [W-1:0] value_next;

    // Comparisons use >= / <= so a value left outside a freshly narrowed
    // range still wraps back into it on the next step.
    always_comb begin
        value_next = value_reg;
        if (init) begin
            value_next = init_val;
        end else if (up && !down) begin
            value_next = (value_reg >= hi) ? lo : value_reg + W'(1);
        end else if (down && !up) begin
            value_next = (value_reg <= lo) ? hi : value_reg - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_reg <= rst_val;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/time_set_entry.sv
// Button-driven time-entry FSM producing edited hours/mins/secs/AM-PM and a
// one-cycle load strobe. Optional hold-to-repeat via TIME_SET_AUTOREPEAT_EN.
module time_set_entry
    import time_set_pkg::*;
#(
    parameter int W             = 6,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_enter,
    input  logic         btn_next,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         mode_12h,
    output logic [W-1:0] hours_o,
    output logic [W-1:0] mins_o,
    output logic [W-1:0] secs_o,
    output logic         A_P_o,
    output logic [1:0]   field_o,
    output logic         editing_o,
    output logic         load_o
);

    localparam int BI_DOWN  = 0;
    localparam int BI_UP    = 1;
    localparam int BI_NEXT  = 2;
    localparam int BI_ENTER = 3;

    logic [3:0] btn_now;
    logic [3:0] btn_reg;
    logic [3:0] btn_prev_reg;
    logic [3:0] press;
    logic       mode_reg;
    logic       mode_prev_reg;
    logic       mode_chg;
    state_t     state_reg;
    state_t     state_next;
    logic       step_en;
    logic       in_hms;
    logic       rpt_up;
    logic       rpt_down;
    logic       up_req;
    logic       down_req;
    logic       step_up;
    logic       step_down;
    logic       a_p_reg;

    assign btn_now  = {btn_enter, btn_next, btn_up, btn_down};
    assign press    = btn_reg & ~btn_prev_reg;
    assign mode_chg = mode_reg ^ mode_prev_reg;
    assign in_hms   = (state_reg == ST_EDIT_H) || (state_reg == ST_EDIT_M) ||
                      (state_reg == ST_EDIT_S);

    // The mode copies reset to the live input so no spurious mode change is
    // seen right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_reg       <= '0;
            btn_prev_reg  <= '0;
            mode_reg      <= mode_12h;
            mode_prev_reg <= mode_12h;
            state_reg     <= ST_IDLE;
        end else begin
            btn_reg       <= btn_now;
            btn_prev_reg  <= btn_reg;
            mode_reg      <= mode_12h;
            mode_prev_reg <= mode_reg;
            state_reg     <= state_next;
        end
    end

    // Priority inside an edit state: enter, then next, then up/down.
    always_comb begin
        state_next = state_reg;
        step_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (press[BI_ENTER]) state_next = ST_EDIT_H;
            end
            ST_EDIT_H: begin
                if (press[BI_ENTER])     state_next = ST_COMMIT;
                else if (press[BI_NEXT]) state_next = ST_EDIT_M;
                else                     step_en    = 1'b1;
            end
            ST_EDIT_M: begin
                if (press[BI_ENTER])     state_next = ST_COMMIT;
                else if (press[BI_NEXT]) state_next = ST_EDIT_S;
                else                     step_en    = 1'b1;
            end
            ST_EDIT_S: begin
                if (press[BI_ENTER])     state_next = ST_COMMIT;
                else if (press[BI_NEXT]) state_next = mode_reg ? ST_EDIT_AP : ST_EDIT_H;
                else                     step_en    = 1'b1;
            end
            ST_EDIT_AP: begin
                if (press[BI_ENTER])     state_next = ST_COMMIT;
                else if (press[BI_NEXT]) state_next = ST_EDIT_H;
                else                     step_en    = 1'b1;
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (mode_chg && !mode_reg && state_reg == ST_EDIT_AP && !press[BI_ENTER]) begin
            state_next = ST_EDIT_H;
            step_en    = 1'b0;
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] hold_cnt_reg;
    logic [CW-1:0] cnt_plus;
    logic          rpt_phase_reg;
    logic          held_alone;
    logic          rpt_fire;

    // Counts cycles held including the press cycle; the first extra step
    // lands on the HOLD_CYCLES-th held cycle, then every REPEAT_CYCLES.
    assign held_alone = in_hms && (btn_reg[BI_UP] ^ btn_reg[BI_DOWN]) &&
                        (state_next == state_reg);
    assign cnt_plus   = hold_cnt_reg + CW'(1);
    assign rpt_fire   = held_alone &&
                        (cnt_plus == (rpt_phase_reg ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_reg  <= '0;
            rpt_phase_reg <= 1'b0;
        end else if (!held_alone) begin
            hold_cnt_reg  <= '0;
            rpt_phase_reg <= 1'b0;
        end else if (rpt_fire) begin
            hold_cnt_reg  <= '0;
            rpt_phase_reg <= 1'b1;
        end else begin
            hold_cnt_reg  <= cnt_plus;
        end
    end

    assign rpt_up   = rpt_fire & btn_reg[BI_UP];
    assign rpt_down = rpt_fire & btn_reg[BI_DOWN];
`else
    assign rpt_up   = 1'b0;
    assign rpt_down = 1'b0;
`endif

    assign up_req    = press[BI_UP] | rpt_up;
    assign down_req  = press[BI_DOWN] | rpt_down;
    assign step_up   = step_en & up_req & ~down_req;
    assign step_down = step_en & down_req & ~up_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_p_reg <= 1'b0;
        end else if (mode_chg) begin
            a_p_reg <= 1'b0;
        end else if (state_reg == ST_EDIT_AP && (step_up || step_down)) begin
            a_p_reg <= ~a_p_reg;
        end
    end

    // Index 0 = hours, 1 = minutes, 2 = seconds (matches the field codes).
    logic [W-1:0] cnt_val      [3];
    logic [W-1:0] cnt_lo       [3];
    logic [W-1:0] cnt_hi       [3];
    logic [W-1:0] cnt_rst_val  [3];
    logic [W-1:0] cnt_init_val [3];
    logic [2:0]   cnt_init;
    logic [2:0]   cnt_up;
    logic [2:0]   cnt_down;

    always_comb begin
        cnt_lo[0]       = mode_reg ? W'(HOURS12_MIN) : '0;
        cnt_hi[0]       = mode_reg ? W'(HOURS12_MAX) : W'(HOURS24_MAX);
        cnt_rst_val[0]  = mode_12h ? W'(HOURS12_MAX) : '0;
        cnt_init_val[0] = mode_reg ? W'(HOURS12_MAX) : '0;
        cnt_init[0]     = mode_chg;
        for (int i = 1; i < 3; i++) begin
            cnt_lo[i]       = '0;
            cnt_hi[i]       = W'(MINSEC_MAX);
            cnt_rst_val[i]  = '0;
            cnt_init_val[i] = '0;
            cnt_init[i]     = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field
            assign cnt_up[gi]   = step_up & in_hms & (state_field(state_reg) == 2'(gi));
            assign cnt_down[gi] = step_down & in_hms & (state_field(state_reg) == 2'(gi));

            wrap_counter #(
                .W(W)
            ) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .rst_val  (cnt_rst_val[gi]),
                .up       (cnt_up[gi]),
                .down     (cnt_down[gi]),
                .lo       (cnt_lo[gi]),
                .hi       (cnt_hi[gi]),
                .init     (cnt_init[gi]),
                .init_val (cnt_init_val[gi]),
                .value    (cnt_val[gi])
            );
        end
    endgenerate

    assign hours_o   = cnt_val[0];
    assign mins_o    = cnt_val[1];
    assign secs_o    = cnt_val[2];
    assign A_P_o     = a_p_reg;
    assign field_o   = state_field(state_reg);
    assign editing_o = (state_reg == ST_EDIT_H) || (state_reg == ST_EDIT_M) ||
                       (state_reg == ST_EDIT_S) || (state_reg == ST_EDIT_AP);
    assign load_o    = (state_reg == ST_COMMIT);

endmodule

// File: tb/tb_time_set_entry.sv
// Directed self-checking bench for time_set_entry; the hold test expects
// auto-repeat only when TIME_SET_AUTOREPEAT_EN is defined.
module tb_time_set_entry;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         btn_enter = 1'b0;
    logic         btn_next = 1'b0;
    logic         btn_up = 1'b0;
    logic         btn_down = 1'b0;
    logic         mode_12h = 1'b0;
    logic [W-1:0] hours_o;
    logic [W-1:0] mins_o;
    logic [W-1:0] secs_o;
    logic         A_P_o;
    logic [1:0]   field_o;
    logic         editing_o;
    logic         load_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    int load_cnt = 0;

    time_set_entry #(
        .W(W),
        .HOLD_CYCLES(4),
        .REPEAT_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_enter (btn_enter),
        .btn_next  (btn_next),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .mode_12h  (mode_12h),
        .hours_o   (hours_o),
        .mins_o    (mins_o),
        .secs_o    (secs_o),
        .A_P_o     (A_P_o),
        .field_o   (field_o),
        .editing_o (editing_o),
        .load_o    (load_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load_o === 1'b1) load_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bits: {enter, next, up, down}; one-cycle pulse then one idle cycle
    task automatic press(input logic [3:0] m);
        {btn_enter, btn_next, btn_up, btn_down} = m;
        tick(1);
        {btn_enter, btn_next, btn_up, btn_down} = 4'b0000;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        mode_12h = 1'b0;
        do_reset();
        $display("test_reset: h=%0d m=%0d s=%0d load=%0b edit=%0b", hours_o, mins_o, secs_o, load_o, editing_o);
        total_cnt++; if (hours_o !== 6'd0) $display("FAIL reset_hours: got %0d expected 0", hours_o); else pass_cnt++;
        total_cnt++; if (mins_o !== 6'd0) $display("FAIL reset_mins: got %0d expected 0", mins_o); else pass_cnt++;
        total_cnt++; if (secs_o !== 6'd0) $display("FAIL reset_secs: got %0d expected 0", secs_o); else pass_cnt++;
        total_cnt++; if (load_o !== 1'b0) $display("FAIL reset_load: got %0b expected 0", load_o); else pass_cnt++;
        total_cnt++; if (editing_o !== 1'b0) $display("FAIL reset_editing: got %0b expected 0", editing_o); else pass_cnt++;
        total_cnt++; if (field_o !== 2'd0) $display("FAIL reset_field: got %0d expected 0", field_o); else pass_cnt++;
        total_cnt++; if (A_P_o !== 1'b0) $display("FAIL reset_ap: got %0b expected 0", A_P_o); else pass_cnt++;
    endtask

    task automatic test_entry_24h();
        load_cnt = 0;
        press(4'b1000);
        total_cnt++; if (editing_o !== 1'b1) $display("FAIL entry_editing: got %0b expected 1", editing_o); else pass_cnt++;
        repeat (3) press(4'b0010);
        total_cnt++; if (hours_o !== 6'd3) $display("FAIL entry_hours_up3: got %0d expected 3", hours_o); else pass_cnt++;
        press(4'b0100);
        total_cnt++; if (field_o !== 2'd1) $display("FAIL entry_field_m: got %0d expected 1", field_o); else pass_cnt++;
        press(4'b0001);
        press(4'b1000);
        tick(2);
        $display("test_entry_24h: h=%0d m=%0d s=%0d loads=%0d", hours_o, mins_o, secs_o, load_cnt);
        total_cnt++; if (load_cnt !== 1) $display("FAIL entry_load_count: got %0d expected 1", load_cnt); else pass_cnt++;
        total_cnt++; if (hours_o !== 6'd3) $display("FAIL entry_hours: got %0d expected 3", hours_o); else pass_cnt++;
        total_cnt++; if (mins_o !== 6'd59) $display("FAIL entry_mins: got %0d expected 59", mins_o); else pass_cnt++;
        total_cnt++; if (secs_o !== 6'd0) $display("FAIL entry_secs: got %0d expected 0", secs_o); else pass_cnt++;
        total_cnt++; if (editing_o !== 1'b0) $display("FAIL entry_idle: got %0b expected 0", editing_o); else pass_cnt++;
    endtask

    task automatic test_wrap();
        mode_12h = 1'b0;
        do_reset();
        press(4'b1000);
        press(4'b0001);
        total_cnt++; if (hours_o !== 6'd23) $display("FAIL wrap_h24_down: got %0d expected 23", hours_o); else pass_cnt++;
        press(4'b0010);
        total_cnt++; if (hours_o !== 6'd0) $display("FAIL wrap_h24_up: got %0d expected 0", hours_o); else pass_cnt++;
        press(4'b0100);
        press(4'b0100);
        total_cnt++; if (field_o !== 2'd2) $display("FAIL wrap_field_s: got %0d expected 2", field_o); else pass_cnt++;
        press(4'b0001);
        total_cnt++; if (secs_o !== 6'd59) $display("FAIL wrap_s_down: got %0d expected 59", secs_o); else pass_cnt++;
        press(4'b0010);
        total_cnt++; if (secs_o !== 6'd0) $display("FAIL wrap_s_up: got %0d expected 0", secs_o); else pass_cnt++;
        press(4'b1000);
        tick(2);
        mode_12h = 1'b1;
        do_reset();
        total_cnt++; if (hours_o !== 6'd12) $display("FAIL wrap_h12_reset: got %0d expected 12", hours_o); else pass_cnt++;
        press(4'b1000);
        press(4'b0010);
        total_cnt++; if (hours_o !== 6'd1) $display("FAIL wrap_h12_up: got %0d expected 1", hours_o); else pass_cnt++;
        press(4'b0001);
        total_cnt++; if (hours_o !== 6'd12) $display("FAIL wrap_h12_down: got %0d expected 12", hours_o); else pass_cnt++;
        press(4'b1000);
        tick(2);
        $display("test_wrap: h=%0d s=%0d", hours_o, secs_o);
    endtask

    task automatic test_ampm();
        load_cnt = 0;
        press(4'b1000);
        repeat (3) press(4'b0100);
        total_cnt++; if (field_o !== 2'd3) $display("FAIL ampm_field: got %0d expected 3", field_o); else pass_cnt++;
        press(4'b0010);
        total_cnt++; if (A_P_o !== 1'b1) $display("FAIL ampm_toggle: got %0b expected 1", A_P_o); else pass_cnt++;
        press(4'b1000);
        tick(2);
        $display("test_ampm: ap=%0b loads=%0d", A_P_o, load_cnt);
        total_cnt++; if (load_cnt !== 1) $display("FAIL ampm_load_count: got %0d expected 1", load_cnt); else pass_cnt++;
        total_cnt++; if (A_P_o !== 1'b1) $display("FAIL ampm_after_commit: got %0b expected 1", A_P_o); else pass_cnt++;
        total_cnt++; if (hours_o !== 6'd12) $display("FAIL ampm_hours: got %0d expected 12", hours_o); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        mode_12h = 1'b0;
        tick(3);
        total_cnt++; if (hours_o !== 6'd0) $display("FAIL mode_chg_hours: got %0d expected 0", hours_o); else pass_cnt++;
        total_cnt++; if (A_P_o !== 1'b0) $display("FAIL mode_chg_ap: got %0b expected 0", A_P_o); else pass_cnt++;
        press(4'b1000);
        press(4'b0010);
        press(4'b0100);
        press(4'b0010);
        load_cnt = 0;
        press(4'b1100);
        tick(2);
        total_cnt++; if (load_cnt !== 1) $display("FAIL simul_enter_next_load: got %0d expected 1", load_cnt); else pass_cnt++;
        total_cnt++; if (mins_o !== 6'd1) $display("FAIL simul_mins_kept: got %0d expected 1", mins_o); else pass_cnt++;
        total_cnt++; if (hours_o !== 6'd1) $display("FAIL simul_hours_kept: got %0d expected 1", hours_o); else pass_cnt++;
        press(4'b1000);
        press(4'b0011);
        total_cnt++; if (hours_o !== 6'd1) $display("FAIL simul_up_down_noop: got %0d expected 1", hours_o); else pass_cnt++;
        total_cnt++; if (field_o !== 2'd0) $display("FAIL simul_field_h: got %0d expected 0", field_o); else pass_cnt++;
        press(4'b1000);
        tick(2);
        $display("test_simultaneous: h=%0d m=%0d loads=%0d", hours_o, mins_o, load_cnt);
    endtask

    task automatic test_reset_mid_edit();
        mode_12h = 1'b0;
        do_reset();
        load_cnt = 0;
        press(4'b1000);
        repeat (5) press(4'b0010);
        total_cnt++; if (hours_o !== 6'd5) $display("FAIL abort_hours_pre: got %0d expected 5", hours_o); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (hours_o !== 6'd0) $display("FAIL abort_async_hours: got %0d expected 0", hours_o); else pass_cnt++;
        tick(2);
        reset = 1'b0;
        tick(3);
        $display("test_reset_mid_edit: h=%0d edit=%0b loads=%0d", hours_o, editing_o, load_cnt);
        total_cnt++; if (load_cnt !== 0) $display("FAIL abort_no_load: got %0d expected 0", load_cnt); else pass_cnt++;
        total_cnt++; if (editing_o !== 1'b0) $display("FAIL abort_idle: got %0b expected 0", editing_o); else pass_cnt++;
        total_cnt++; if (hours_o !== 6'd0) $display("FAIL abort_hours: got %0d expected 0", hours_o); else pass_cnt++;
        press(4'b0010);
        total_cnt++; if (hours_o !== 6'd0) $display("FAIL idle_up_ignored: got %0d expected 0", hours_o); else pass_cnt++;
    endtask

    task automatic test_hold();
        int exp_h;
`ifdef TIME_SET_AUTOREPEAT_EN
        exp_h = 5;
`else
        exp_h = 1;
`endif
        mode_12h = 1'b0;
        do_reset();
        press(4'b1000);
        btn_up = 1'b1;
        tick(10);
        btn_up = 1'b0;
        tick(3);
        $display("test_hold: h=%0d", hours_o);
        total_cnt++; if (hours_o !== W'(exp_h)) $display("FAIL hold_up_10: got %0d expected %0d", hours_o, exp_h); else pass_cnt++;
        press(4'b1000);
        tick(2);
    endtask

    initial begin
        test_reset();
        test_entry_24h();
        test_wrap();
        test_ampm();
        test_simultaneous();
        test_reset_mid_edit();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
